// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC controller: sequential fetch, redirect, stall, backpressure, halt
// Drives the fetch PC register input/enable and generates pipeline flush strobes.
module pc_sequencer #(
  parameter int                ADDR_W       = 64,
  parameter int                INSTR_BYTES  = 4,
  parameter int                FLUSH_CYCLES = 2,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_current,
  input  logic              stall_i,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              imem_ready,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_write,
  output logic              if_valid,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              halted,
  output logic              misalign_err,
  output logic [31:0]       stall_count
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic        misalign_d;
  logic [31:0] stall_count_d;
  logic [ADDR_W-1:0] pc_seq;

  assign pc_seq = pc_current + ADDR_W'(INSTR_BYTES);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      flush_cnt_q  <= 4'd0;
      misalign_err <= 1'b0;
      stall_count  <= 32'd0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      misalign_err <= misalign_d;
      stall_count  <= stall_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    misalign_d    = misalign_err;
    stall_count_d = stall_count;
    pc_next       = pc_current;
    pc_write      = 1'b0;
    if_valid      = 1'b0;
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;
    halted        = 1'b0;

    if (reset) begin
      pc_next = RESET_VECTOR;
    end else begin
      unique case (state_q)
        FETCH, STALL: begin
          if (halt_req) begin
            state_d = HALTED;
          end else if (branch_taken && (branch_target[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
            state_d    = HALTED;
          end else if (branch_taken) begin
            // Redirect wins over stall and backpressure; the target is loaded now.
            pc_next    = branch_target;
            pc_write   = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d     = FLUSH;
              flush_cnt_d = 4'(FLUSH_CYCLES - 1);
            end else begin
              state_d = FETCH;
            end
          end else if (stall_i) begin
            flush_idex = 1'b1;
            state_d    = STALL;
            if (stall_count != 32'hFFFF_FFFF)
              stall_count_d = stall_count + 32'd1;
          end else if (!imem_ready) begin
            state_d = FETCH;
          end else begin
            pc_next  = pc_seq;
            pc_write = 1'b1;
            if_valid = 1'b1;
            state_d  = FETCH;
          end
        end
        FLUSH: begin
          // Wrong-path cycles: branch/stall ignored, only ready cycles consume the count.
          pc_next    = pc_seq;
          pc_write   = imem_ready;
          flush_ifid = 1'b1;
          if (halt_req) begin
            state_d = HALTED;
          end else if (imem_ready) begin
            flush_cnt_d = flush_cnt_q - 4'd1;
            if (flush_cnt_q <= 4'd1)
              state_d = FETCH;
          end
        end
        HALTED: begin
          halted = 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with a PC register model
// Driver pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] pc_current;
  logic        stall_i = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = '0;
  logic        imem_ready = 1'b1;
  logic        halt_req = 1'b0;
  logic [63:0] pc_next;
  logic        pc_write, if_valid, flush_ifid, flush_idex, halted, misalign_err;
  logic [31:0] stall_count;

  logic        pc_ovr_en = 1'b0;
  logic [63:0] pc_ovr = '0;
  logic [63:0] pc_reg;

  int tests = 0;
  int failed = 0;

  typedef struct {
    string       name;
    bit          pc_chk;
    logic [63:0] pc;
    logic        pw, ifv, fi, fx, hl;
    bit          reg_chk;
    logic        me;
    logic [31:0] sc;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .pc_current    (pc_current),
    .stall_i       (stall_i),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_ready    (imem_ready),
    .halt_req      (halt_req),
    .pc_next       (pc_next),
    .pc_write      (pc_write),
    .if_valid      (if_valid),
    .flush_ifid    (flush_ifid),
    .flush_idex    (flush_idex),
    .halted        (halted),
    .misalign_err  (misalign_err),
    .stall_count   (stall_count)
  );

  // PC register model; an override lets the bench place pc_current anywhere.
  assign pc_current = pc_ovr_en ? pc_ovr : pc_reg;
  always_ff @(posedge clk) begin
    if (reset)         pc_reg <= 64'd0;
    else if (pc_write) pc_reg <= pc_next;
    else               pc_reg <= pc_current;
  end

  task automatic check(input string n, input string f, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s.%s got %h expected %h", n, f, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.pc_chk) check(e.name, "pc_next", pc_next, e.pc);
      check(e.name, "pc_write",   64'(pc_write),   64'(e.pw));
      check(e.name, "if_valid",   64'(if_valid),   64'(e.ifv));
      check(e.name, "flush_ifid", 64'(flush_ifid), 64'(e.fi));
      check(e.name, "flush_idex", 64'(flush_idex), 64'(e.fx));
      check(e.name, "halted",     64'(halted),     64'(e.hl));
      if (e.reg_chk) begin
        check(e.name, "misalign_err", 64'(misalign_err), 64'(e.me));
        check(e.name, "stall_count",  64'(stall_count),  64'(e.sc));
      end
    end
  end

  task automatic vec(input string n, input bit rst, input bit ovr, input logic [63:0] pco,
                     input bit st, input bit br, input logic [63:0] tg, input bit rdy, input bit hr,
                     input bit pchk, input logic [63:0] epc, input bit epw, input bit eifv,
                     input bit efi, input bit efx, input bit ehl,
                     input bit rchk, input bit eme, input logic [31:0] esc);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; pc_ovr_en = ovr; pc_ovr = pco;
    stall_i = st; branch_taken = br; branch_target = tg; imem_ready = rdy; halt_req = hr;
    e.name = n; e.pc_chk = pchk; e.pc = epc; e.pw = epw; e.ifv = eifv; e.fi = efi;
    e.fx = efx; e.hl = ehl; e.reg_chk = rchk; e.me = eme; e.sc = esc;
    exp_q.push_back(e);
  endtask

  initial begin
    //    name        rst ovr pco                    st br tgt      rdy hr  pchk pc       pw iv fi fx hl rchk me sc
    vec("rst0",       1, 0, 64'h0,                   0, 0, 64'h0,   1, 0,  1, 64'h0,     0, 0, 0, 0, 0,  0, 0, 0);
    vec("rst1",       1, 0, 64'h0,                   1, 1, 64'h100, 1, 1,  1, 64'h0,     0, 0, 0, 0, 0,  1, 0, 0);
    vec("seq0",       0, 0, 64'h0,                   0, 0, 64'h0,   1, 0,  1, 64'h4,     1, 1, 0, 0, 0,  1, 0, 0);
    vec("seq4",       0, 0, 64'h0,                   0, 0, 64'h0,   1, 0,  1, 64'h8,     1, 1, 0, 0, 0,  1, 0, 0);
    vec("seq8",       0, 0, 64'h0,                   0, 0, 64'h0,   1, 0,  1, 64'hc,     1, 1, 0, 0, 0,  1, 0, 0);
    vec("seq12",      0, 0, 64'h0,                   0, 0, 64'h0,   1, 0,  1, 64'h10,    1, 1, 0, 0, 0,  1, 0, 0);
    vec("br100",      0, 0, 64'h0,                   0, 1, 64'h100, 1, 0,  1, 64'h100,   1, 0, 1, 1, 0,  1, 0, 0);
    vec("flush104",   0, 0, 64'h0,                   1, 1, 64'h300, 1, 0,  1, 64'h104,   1, 0, 1, 0, 0,  1, 0, 0);
    vec("fetch104",   0, 0, 64'h0,                   0, 0, 64'h0,   1, 0,  1, 64'h108,   1, 1, 0, 0, 0,  1, 0, 0);
    vec("stall1",     0, 1, 64'h20,                  1, 0, 64'h0,   1, 0,  1, 64'h20,    0, 0, 0, 1, 0,  1, 0, 0);
    vec("stall2",     0, 0, 64'h0,                   1, 0, 64'h0,   1, 0,  1, 64'h20,    0, 0, 0, 1, 0,  1, 0, 1);
    vec("stall3",     0, 0, 64'h0,                   1, 0, 64'h0,   1, 0,  1, 64'h20,    0, 0, 0, 1, 0,  1, 0, 2);
    vec("resume",     0, 0, 64'h0,                   0, 0, 64'h0,   1, 0,  1, 64'h24,    1, 1, 0, 0, 0,  1, 0, 3);
    vec("br_vs_st",   0, 0, 64'h0,                   1, 1, 64'h200, 1, 0,  1, 64'h200,   1, 0, 1, 1, 0,  1, 0, 3);
    vec("flush_nr1",  0, 0, 64'h0,                   0, 0, 64'h0,   0, 0,  1, 64'h204,   0, 0, 1, 0, 0,  1, 0, 3);
    vec("flush_nr2",  0, 0, 64'h0,                   0, 0, 64'h0,   0, 0,  1, 64'h204,   0, 0, 1, 0, 0,  1, 0, 3);
    vec("flush_rdy",  0, 0, 64'h0,                   0, 0, 64'h0,   1, 0,  1, 64'h204,   1, 0, 1, 0, 0,  1, 0, 3);
    vec("fetch204",   0, 0, 64'h0,                   0, 0, 64'h0,   1, 0,  1, 64'h208,   1, 1, 0, 0, 0,  1, 0, 3);
    vec("imem_busy",  0, 0, 64'h0,                   0, 0, 64'h0,   0, 0,  0, 64'h0,     0, 0, 0, 0, 0,  1, 0, 3);
    vec("wrap",       0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'h0,   1, 0,  1, 64'h0,     1, 1, 0, 0, 0,  1, 0, 3);
    vec("after_wrap", 0, 0, 64'h0,                   0, 0, 64'h0,   1, 0,  1, 64'h4,     1, 1, 0, 0, 0,  1, 0, 3);
    vec("misalign",   0, 0, 64'h0,                   0, 1, 64'h102, 1, 0,  0, 64'h0,     0, 0, 0, 0, 0,  1, 0, 3);
    vec("halted_br",  0, 0, 64'h0,                   0, 1, 64'h400, 1, 0,  0, 64'h0,     0, 0, 0, 0, 1,  1, 1, 3);
    vec("halted_st",  0, 0, 64'h0,                   1, 0, 64'h0,   1, 0,  0, 64'h0,     0, 0, 0, 0, 1,  1, 1, 3);
    vec("rst_halt0",  1, 0, 64'h0,                   0, 0, 64'h0,   1, 0,  1, 64'h0,     0, 0, 0, 0, 0,  1, 1, 3);
    vec("rst_halt1",  1, 0, 64'h0,                   0, 0, 64'h0,   1, 0,  1, 64'h0,     0, 0, 0, 0, 0,  1, 0, 0);
    vec("post_rst",   0, 0, 64'h0,                   0, 0, 64'h0,   1, 0,  1, 64'h4,     1, 1, 0, 0, 0,  1, 0, 0);
    vec("halt_req",   0, 0, 64'h0,                   0, 0, 64'h0,   1, 1,  0, 64'h0,     0, 0, 0, 0, 0,  1, 0, 0);
    vec("halt_hold",  0, 0, 64'h0,                   0, 0, 64'h0,   1, 0,  0, 64'h0,     0, 0, 0, 0, 1,  1, 0, 0);
    vec("rst_again",  1, 0, 64'h0,                   0, 0, 64'h0,   1, 0,  1, 64'h0,     0, 0, 0, 0, 0,  1, 0, 0);
    vec("restart",    0, 0, 64'h0,                   0, 0, 64'h0,   1, 0,  1, 64'h4,     1, 1, 0, 0, 0,  1, 0, 0);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
